// File: rtl/bn128_jb_point_deserializer.sv
// Rebuilds a 768-bit BN128 Jacobian point {z,y,x} from a two-beat result stream ({y,x} then {--,z}).
// Stream interfaces are flattened into <if>_<field> ports; framing errors are pulsed and counted.
module bn128_jb_point_deserializer #(
  parameter int DAT_BITS     = 512,
  parameter int FE_BITS      = 256,
  parameter int ERR_CNT_BITS = 16,
  parameter int PNT_CNT_BITS = 64,
  localparam int PNT_BITS    = 3 * FE_BITS,
  localparam int MOD_BITS    = $clog2(PNT_BITS / 8)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_res_if_val,
  output logic                    i_res_if_rdy,
  input  logic                    i_res_if_sop,
  input  logic                    i_res_if_eop,
  input  logic [DAT_BITS-1:0]     i_res_if_dat,
  output logic                    o_pnt_if_val,
  input  logic                    o_pnt_if_rdy,
  output logic                    o_pnt_if_sop,
  output logic                    o_pnt_if_eop,
  output logic                    o_pnt_if_err,
  output logic [0:0]              o_pnt_if_ctl,
  output logic [MOD_BITS-1:0]     o_pnt_if_mod,
  output logic [PNT_BITS-1:0]     o_pnt_if_dat,
  output logic [PNT_CNT_BITS-1:0] o_pnt_cnt,
  output logic [ERR_CNT_BITS-1:0] o_err_cnt,
  output logic                    o_err
);

  typedef enum logic [0:0] {
    S_XY = 1'b0,
    S_Z  = 1'b1
  } state_t;

  localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = {ERR_CNT_BITS{1'b1}};
  localparam logic [ERR_CNT_BITS-1:0] ERR_ONE = {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [PNT_CNT_BITS-1:0] PNT_ONE = {{(PNT_CNT_BITS-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [FE_BITS-1:0] x_h_r;
  logic [FE_BITS-1:0] y_h_r;
  logic               out_free_s;
  logic               beat_acc_s;
  logic               drain_s;
  logic               frame_err_s;
  logic               ld_xy_s;
  logic               ld_pnt_s;

  assign out_free_s = ~o_pnt_if_val | o_pnt_if_rdy;
  assign beat_acc_s = i_res_if_val & i_res_if_rdy;
  assign drain_s    = o_pnt_if_val & o_pnt_if_rdy;

  // Input ready: beat0-type beats never wait; only a beat1 in S_Z waits for the output slot
  always_comb begin
    i_res_if_rdy = 1'b1;
    case (state_r)
      S_XY: i_res_if_rdy = 1'b1;
      S_Z: begin
        if (i_res_if_sop) begin
          i_res_if_rdy = 1'b1;
        end else begin
          i_res_if_rdy = out_free_s;
        end
      end
      default: i_res_if_rdy = 1'b1;
    endcase
  end

  // Framing decode of the accepted beat
  always_comb begin
    frame_err_s = 1'b0;
    ld_xy_s     = 1'b0;
    ld_pnt_s    = 1'b0;
    state_nxt_s = state_r;
    if (beat_acc_s) begin
      case (state_r)
        S_XY: begin
          if (i_res_if_sop && !i_res_if_eop) begin
            ld_xy_s     = 1'b1;
            state_nxt_s = S_Z;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        S_Z: begin
          case ({i_res_if_sop, i_res_if_eop})
            2'b01: begin
              ld_pnt_s    = 1'b1;
              state_nxt_s = S_XY;
            end
            2'b10: begin
              // Early sop: drop the partial point and treat this beat as a fresh beat0
              frame_err_s = 1'b1;
              ld_xy_s     = 1'b1;
              state_nxt_s = S_Z;
            end
            default: begin
              frame_err_s = 1'b1;
              state_nxt_s = S_XY;
            end
          endcase
        end
        default: begin
          state_nxt_s = S_XY;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, hold registers, output point register and counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= S_XY;
      x_h_r        <= {FE_BITS{1'b0}};
      y_h_r        <= {FE_BITS{1'b0}};
      o_pnt_if_val <= 1'b0;
      o_pnt_if_sop <= 1'b0;
      o_pnt_if_eop <= 1'b0;
      o_pnt_if_err <= 1'b0;
      o_pnt_if_ctl <= 1'b0;
      o_pnt_if_mod <= {MOD_BITS{1'b0}};
      o_pnt_if_dat <= {PNT_BITS{1'b0}};
      o_pnt_cnt    <= {PNT_CNT_BITS{1'b0}};
      o_err_cnt    <= {ERR_CNT_BITS{1'b0}};
      o_err        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      o_pnt_if_err <= 1'b0;
      o_pnt_if_ctl <= 1'b0;
      o_pnt_if_mod <= {MOD_BITS{1'b0}};
      o_err        <= frame_err_s;
      if (ld_xy_s) begin
        x_h_r <= i_res_if_dat[0 +: FE_BITS];
        y_h_r <= i_res_if_dat[FE_BITS +: FE_BITS];
      end
      if (ld_pnt_s) begin
        o_pnt_if_val <= 1'b1;
        o_pnt_if_sop <= 1'b1;
        o_pnt_if_eop <= 1'b1;
        o_pnt_if_dat <= {i_res_if_dat[0 +: FE_BITS], y_h_r, x_h_r};
      end else if (drain_s) begin
        o_pnt_if_val <= 1'b0;
      end
      if (drain_s) begin
        o_pnt_cnt <= o_pnt_cnt + PNT_ONE;
      end
      if (frame_err_s && (o_err_cnt != ERR_MAX)) begin
        o_err_cnt <= o_err_cnt + ERR_ONE;
      end
    end
  end

endmodule
